// File: rtl/pwm_capture_if.sv
// Capture-side bundle for the PWM measurement block.
// The master side drives the enable and the raw PWM line. The slave side,
// which is the capture block, returns the measurement and its status pulses.
interface pwm_capture_if;
  logic        en;
  logic        pwm_in;
  logic [11:0] period_out;
  logic [11:0] pulsewidth_out;
  logic        valid;
  logic        frame_done;
  logic        timeout;

  modport master (
    output en, pwm_in,
    input  period_out, pulsewidth_out, valid, frame_done, timeout
  );

  modport slave (
    input  en, pwm_in,
    output period_out, pulsewidth_out, valid, frame_done, timeout
  );
endinterface

// File: rtl/pwm_capture.sv
// PWM capture: measures the frame length and the high time of an
// asynchronous PWM line, using the same encoding as the PWM generator.
//   period_out     = frame length - 1
//   pulsewidth_out = high cycles
// A frame is reported only after two synchronized rising edges. Missing
// edges end in a one-cycle timeout pulse and drop valid.
module pwm_capture (
  input  logic            clk,
  input  logic            rst,
  pwm_capture_if.slave    bus
);

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  // A fall must arrive while elapsed is still below this value.
  localparam logic [12:0] HIGH_LIMIT = 13'd4096;
  // A rise must arrive while elapsed is still below this value.
  // It is one more than HIGH_LIMIT so that the longest frame,
  // period_out = 4095, is still measurable.
  localparam logic [12:0] LOW_LIMIT  = 13'd4097;

  logic        s1_q, s2_q, s3_q;
  logic        rise, fall;
  state_t      state_q;
  logic [12:0] elapsed_q;
  logic [11:0] pw_shadow_q;
  logic [11:0] period_q, pulsewidth_q;
  logic        valid_q, frame_done_q, timeout_q;

  // Two-flop synchronizer plus a history flop for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= bus.pwm_in;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign rise = s2_q & ~s3_q;
  assign fall = ~s2_q & s3_q;

  // Measurement FSM.
  // The elapsed value at each edge is the cycle count since the last rise.
  // Both output fields change together, and only on a commit.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      elapsed_q    <= '0;
      pw_shadow_q  <= '0;
      period_q     <= '0;
      pulsewidth_q <= '0;
      valid_q      <= 1'b0;
      frame_done_q <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      timeout_q    <= 1'b0;
      if (!bus.en) begin
        // Drop the frame in progress but keep the last reported measurement.
        state_q     <= IDLE;
        valid_q     <= 1'b0;
        elapsed_q   <= '0;
        pw_shadow_q <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (rise) begin
              state_q   <= HIGH;
              elapsed_q <= 13'd1;
            end else begin
              elapsed_q <= '0;
            end
          end
          HIGH: begin
            if (fall) begin
              pw_shadow_q <= elapsed_q[11:0];
              state_q     <= LOW;
              elapsed_q   <= elapsed_q + 13'd1;
            end else if (elapsed_q == HIGH_LIMIT) begin
              // Stuck high (100% duty).
              timeout_q <= 1'b1;
              valid_q   <= 1'b0;
              state_q   <= IDLE;
              elapsed_q <= '0;
            end else begin
              elapsed_q <= elapsed_q + 13'd1;
            end
          end
          LOW: begin
            if (rise) begin
              // Wraps to 4095 when elapsed is 4096, the longest legal frame.
              period_q     <= elapsed_q[11:0] - 12'd1;
              pulsewidth_q <= pw_shadow_q;
              valid_q      <= 1'b1;
              frame_done_q <= 1'b1;
              state_q      <= HIGH;
              elapsed_q    <= 13'd1;
            end else if (elapsed_q == LOW_LIMIT) begin
              // Stuck low (0% duty).
              timeout_q <= 1'b1;
              valid_q   <= 1'b0;
              state_q   <= IDLE;
              elapsed_q <= '0;
            end else begin
              elapsed_q <= elapsed_q + 13'd1;
            end
          end
          default: begin
            state_q   <= IDLE;
            elapsed_q <= '0;
          end
        endcase
      end
    end
  end

  assign bus.period_out     = period_q;
  assign bus.pulsewidth_out = pulsewidth_q;
  assign bus.valid          = valid_q;
  assign bus.frame_done     = frame_done_q;
  assign bus.timeout        = timeout_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture.
// A timestamp model predicts every output on every cycle. Directed phases
// with literal expectations pin the model.
module tb_pwm_capture;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pwm_capture_if bus();
  pwm_capture dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;

  // ---------------- reference model ----------------
  // hist[k] holds the pwm_in value sampled at model edge k.
  // Samples at or before the latest reset edge count as 0.
  // The edge detect seen in the cycle ending at edge e compares the
  // samples from edges e-2 and e-3.
  // elapsed at edge e is e minus the edge that closed the last rise cycle.
  bit hist[$];
  int edge_n = 0;
  int clr_edge = -1;
  bit busy = 0;
  bit fall_seen = 0;
  int t_rise = 0;
  int pw_sh = 0;
  int ep = 0, epw = 0;
  bit ev = 0, efd = 0, eto = 0;
  bit stepped = 0;

  function automatic bit val(input int k);
    if (k < 0 || k <= clr_edge) return 1'b0;
    return hist[k];
  endfunction

  task automatic model_step();
    int e;
    int el;
    bit r, f;
    e = edge_n;
    hist.push_back(bus.pwm_in);
    r = val(e-2) && !val(e-3);
    f = !val(e-2) && val(e-3);
    efd = 0;
    eto = 0;
    if (rst) begin
      clr_edge = e;
      ep = 0;
      epw = 0;
      ev = 0;
      busy = 0;
    end else if (!bus.en) begin
      ev = 0;
      busy = 0;
    end else if (!busy) begin
      if (r) begin
        busy = 1;
        t_rise = e;
        fall_seen = 0;
      end
    end else begin
      el = e - t_rise;
      if (!fall_seen) begin
        if (f) begin
          fall_seen = 1;
          pw_sh = el % 4096;
        end else if (el == 4096) begin
          eto = 1;
          ev = 0;
          busy = 0;
        end
      end else begin
        if (r) begin
          ep = el - 1;
          epw = pw_sh;
          ev = 1;
          efd = 1;
          t_rise = e;
          fall_seen = 0;
        end else if (el == 4097) begin
          eto = 1;
          ev = 0;
          busy = 0;
        end
      end
    end
    edge_n++;
  endtask

  // Per-cycle compare against the model, then advance the model with the
  // inputs the DUT will see at the next rising edge.
  always @(negedge clk) begin
    if (stepped) begin
      checks++;
      if (bus.period_out !== ep[11:0] || bus.pulsewidth_out !== epw[11:0] ||
          bus.valid !== ev || bus.frame_done !== efd || bus.timeout !== eto) begin
        errors++;
        $display("FAIL cycle_cmp t=%0t got p=%0d pw=%0d v=%b fd=%b to=%b want p=%0d pw=%0d v=%b fd=%b to=%b",
                 $time, bus.period_out, bus.pulsewidth_out, bus.valid, bus.frame_done,
                 bus.timeout, ep, epw, ev, efd, eto);
      end
    end
    model_step();
    stepped = 1;
  end

  // ---------------- directed stimulus ----------------
  int cyc = 0;
  int fd_times[$];
  int to_times[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  // One clock: record the pulses seen after this edge, then set pwm_in for
  // the next edge.
  task automatic tick(input bit p);
    @(posedge clk);
    #1;
    cyc++;
    if (bus.frame_done) fd_times.push_back(cyc);
    if (bus.timeout) to_times.push_back(cyc);
    bus.pwm_in = p;
  endtask

  // Generator encoding: a frame of period+1 cycles, high for pw cycles.
  task automatic gen(input int period, input int pw, input int n);
    for (int f = 0; f < n; f++)
      for (int c = 0; c <= period; c++)
        tick(c < pw);
  endtask

  task automatic clear_q();
    fd_times.delete();
    to_times.delete();
  endtask

  initial begin
    bus.en = 1'b0;
    bus.pwm_in = 1'b0;
    repeat (3) tick(0);
    rst = 1'b0;
    tick(0);
    chk("reset_period", bus.period_out, 0);
    chk("reset_pw", bus.pulsewidth_out, 0);
    chk("reset_valid", bus.valid, 0);

    // Loopback at period 9 / pulsewidth 3, then hold the input low.
    bus.en = 1'b1;
    clear_q();
    gen(9, 3, 6);
    chk("p9_period", bus.period_out, 9);
    chk("p9_pw", bus.pulsewidth_out, 3);
    chk("p9_valid", bus.valid, 1);
    chk("p9_fd_count", fd_times.size(), 5);
    for (int i = 1; i < fd_times.size(); i++)
      chk("p9_fd_interval", fd_times[i] - fd_times[i-1], 10);
    repeat (4110) tick(0);
    chk("low_to_count", to_times.size(), 1);
    if (to_times.size() == 1 && fd_times.size() > 0)
      chk("low_to_gap", to_times[0] - fd_times[fd_times.size()-1], 4097);
    chk("low_valid", bus.valid, 0);
    chk("low_hold_period", bus.period_out, 9);
    chk("low_hold_pw", bus.pulsewidth_out, 3);

    // Restart from IDLE, then hold the input high.
    clear_q();
    gen(9, 3, 3);
    repeat (4110) tick(1);
    chk("high_fd_count", fd_times.size(), 3);
    chk("high_to_count", to_times.size(), 1);
    if (to_times.size() == 1 && fd_times.size() > 0)
      chk("high_to_gap", to_times[0] - fd_times[fd_times.size()-1], 4096);
    chk("high_valid", bus.valid, 0);
    repeat (5) tick(0);

    // Reset while the FSM is in LOW.
    gen(9, 3, 2);
    repeat (3) tick(1);
    repeat (4) tick(0);
    rst = 1'b1;
    tick(0);
    rst = 1'b0;
    chk("rst_low_period", bus.period_out, 0);
    chk("rst_low_pw", bus.pulsewidth_out, 0);
    chk("rst_low_valid", bus.valid, 0);
    chk("rst_low_fd", bus.frame_done, 0);
    clear_q();
    gen(9, 3, 3);
    chk("rst_fd_count", fd_times.size(), 2);
    chk("rst_period", bus.period_out, 9);

    // One-cycle enable drop in the middle of the stream.
    gen(9, 3, 2);
    bus.en = 1'b0;
    tick(0);
    bus.en = 1'b1;
    chk("en_valid", bus.valid, 0);
    chk("en_hold_period", bus.period_out, 9);
    chk("en_hold_pw", bus.pulsewidth_out, 3);
    clear_q();
    gen(9, 3, 3);
    chk("en_fd_count", fd_times.size(), 2);
    chk("en_valid_back", bus.valid, 1);

    // Longest frame: period 4095, pulsewidth 4095.
    clear_q();
    gen(4095, 4095, 3);
    chk("max_period", bus.period_out, 4095);
    chk("max_pw", bus.pulsewidth_out, 4095);
    chk("max_valid", bus.valid, 1);
    chk("max_no_timeout", to_times.size(), 0);

    repeat (4) tick(0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pwm_capture.md
PWM_CAPTURE -- requirements
Module: pwm_capture

Interface
REQ-001 The block SHALL have no parameters; all measurement fields SHALL be fixed at 12 bits.
REQ-002 clk  input  1  system clock; all state SHALL update on its rising edge only.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 en  input  1  capture enable; low SHALL force the idle condition.
REQ-005 pwm_in  input  1  asynchronous PWM input, active-high pulse.
REQ-006 period_out  output  12  last measured frame length in clk cycles minus 1, in the same encoding as the PWM generator's period input.
REQ-007 pulsewidth_out  output  12  last measured high time in clk cycles, in the same encoding as the PWM generator's pulsewidth input.
REQ-008 valid  output  1  level; period_out and pulsewidth_out hold a coherent measurement.
REQ-009 frame_done  output  1  one-cycle pulse when a new measurement is committed.
REQ-010 timeout  output  1  one-cycle pulse when an expected edge is not seen in time.

Function
REQ-011 pwm_in SHALL pass through a 2-flop synchronizer, then a third history flop; rise = s2 & ~s3, fall = ~s2 & s3.
REQ-012 All measurements SHALL use only synchronized edges, so fixed input latency SHALL NOT affect measured values.
REQ-013 A 13-bit counter "elapsed" SHALL be loaded with 1 on the cycle after any rise detect, and SHALL increment by 1 on every other cycle while in HIGH or LOW.
REQ-014 The value of elapsed on a detect cycle SHALL equal the number of clk cycles since the previous rise detect.
REQ-015 The FSM SHALL have states IDLE, HIGH and LOW, and SHALL enter IDLE on reset.
REQ-016 IDLE: on rise, the FSM SHALL go to HIGH; otherwise it SHALL stay in IDLE; elapsed SHALL be held at 0.
REQ-017 HIGH: on fall, the block SHALL latch elapsed[11:0] into an internal pw_shadow and go to LOW.
REQ-018 HIGH: if elapsed reaches 4096 with no fall, the block SHALL pulse timeout, clear valid and go to IDLE.
REQ-019 LOW: on rise, the block SHALL commit period_out = elapsed-1 and pulsewidth_out = pw_shadow in the same cycle, set valid, pulse frame_done, and go to HIGH.
REQ-020 LOW: if elapsed reaches 4097 with no rise, the block SHALL pulse timeout, clear valid and go to IDLE.
REQ-021 period_out and pulsewidth_out SHALL update only together on a commit, so a partial frame SHALL never be visible.
REQ-022 The first measurement SHALL be committed on the second rise after leaving IDLE; the first, partial frame SHALL NOT be reported.
REQ-023 Constant-low input (0% duty) and constant-high input (100% duty) SHALL both resolve to timeout, with valid = 0.
REQ-024 en low SHALL force IDLE and clear valid, elapsed and pw_shadow in the next cycle, while period_out and pulsewidth_out hold.
REQ-025 After en returns high, the full first-frame rule (REQ-022) SHALL apply again.
REQ-026 Only one of frame_done and timeout SHALL ever be asserted in a given cycle.

Reset
REQ-027 On rst, the block SHALL set state IDLE and clear period_out, pulsewidth_out, elapsed, pw_shadow, valid, frame_done, timeout and all synchronizer flops to 0.
REQ-028 rst SHALL take priority over en and over any edge detected in the same cycle.
REQ-029 A reset mid-frame SHALL discard the frame in progress, and no frame_done SHALL follow from that frame.

Verification
REQ-030 Loopback from the PWM generator with period=9, pulsewidth=3: on the second rise, period_out=9, pulsewidth_out=3 and valid=1; frame_done SHALL then pulse every 10 cycles.
REQ-031 Generator with period=4095, pulsewidth=4095: period_out=4095, pulsewidth_out=4095, and timeout SHALL never assert.
REQ-032 pwm_in held low after valid measurements: timeout SHALL pulse 4097 cycles after the last rise detect, valid SHALL go to 0, and the outputs SHALL hold their last values.
REQ-033 pwm_in held high: timeout SHALL pulse 4096 cycles after the rise detect, and the FSM SHALL go to IDLE.
REQ-034 rst asserted in LOW state with period=9, pulsewidth=3: all outputs SHALL be 0 on the next cycle, and the first frame_done SHALL occur only after two further rises.
REQ-035 en dropped for 1 cycle mid-stream: valid SHALL go to 0, period_out and pulsewidth_out SHALL hold, and valid SHALL return on the second rise after en returns high.
